// File: rtl/pkt_rx_if.sv
// Router-side packet input and core-side head output of the NoC receive unit.
// master drives packets in and out_ready; slave is the receive unit itself.
interface pkt_rx_if;
  logic [32:0] pkt_in;
  logic        pkt_valid;
  logic        pkt_ready;
  logic [3:0]  out_opcode;
  logic [24:0] out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output pkt_in, pkt_valid, out_ready,
    input  pkt_ready, out_opcode, out_data, out_valid
  );

  modport slave (
    input  pkt_in, pkt_valid, out_ready,
    output pkt_ready, out_opcode, out_data, out_valid
  );
endinterface

// File: rtl/pkt_rx_unit.sv
// NoC receive unit: address filter, DEPTH-entry fall-through FIFO, saturating stats; accepted packet visible the cycle after its edge.
// Backpressure: pkt_ready low while full or in reset (no pass-through on full); mismatched packets are consumed and dropped.
module pkt_rx_unit #(
  parameter logic [3:0] NODE_ID    = 4'd0,
  parameter bit         ACCEPT_ANY = 1'b0,
  parameter int         DEPTH      = 4,
  parameter int         CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pkt_rx_if.slave                bus,
  output logic [CNT_W-1:0]       rx_count,
  output logic [CNT_W-1:0]       drop_count,
  output logic [$clog2(DEPTH):0] fifo_level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] rx_q, rx_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [28:0]      mem_q [DEPTH];
  logic [28:0]      mem_d [DEPTH];

  logic addr_hit, in_fire, push, drop, pop, head_vld;

  assign addr_hit      = ACCEPT_ANY || (bus.pkt_in[32:29] == NODE_ID);
  assign bus.pkt_ready = !rst && (level_q != FULL);
  assign head_vld      = (level_q != '0);
  assign in_fire       = bus.pkt_valid && bus.pkt_ready;
  assign push          = in_fire && addr_hit;
  assign drop          = in_fire && !addr_hit;
  assign pop           = head_vld && bus.out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rx_d     = rx_q;
    drop_d   = drop_q;

    if (push) begin
      mem_d[wr_ptr_q] = bus.pkt_in[28:0];
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // Statistics stick at all-ones instead of wrapping.
    if (push && (rx_q != '1)) begin
      rx_d = rx_q + CNT_W'(1);
    end
    if (drop && (drop_q != '1)) begin
      drop_d = drop_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      rx_q     <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      rx_q     <= rx_d;
      drop_q   <= drop_d;
    end
  end

  // Storage is left unreset; the empty mask below keeps stale/X contents off the outputs.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.out_valid = head_vld;
  assign {bus.out_opcode, bus.out_data} = head_vld ? mem_q[rd_ptr_q] : 29'd0;

  assign rx_count   = rx_q;
  assign drop_count = drop_q;
  assign fifo_level = level_q;
endmodule

// File: tb/tb_pkt_rx_unit.sv
// Directed bench for pkt_rx_unit: a vector table on the default node plus hand sequences
// for back-to-back flow, reset flush, ACCEPT_ANY and narrow saturating counters.
module tb_pkt_rx_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [32:0] pkt_in = '0;
  logic        pkt_valid = 1'b0;
  logic        out_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  pkt_rx_if ifa ();
  pkt_rx_if ifb ();
  pkt_rx_if ifc ();

  assign ifa.pkt_in = pkt_in;  assign ifa.pkt_valid = pkt_valid;  assign ifa.out_ready = out_ready;
  assign ifb.pkt_in = pkt_in;  assign ifb.pkt_valid = pkt_valid;  assign ifb.out_ready = out_ready;
  assign ifc.pkt_in = pkt_in;  assign ifc.pkt_valid = pkt_valid;  assign ifc.out_ready = out_ready;

  logic [15:0] rx_a, drop_a, rx_b, drop_b;
  logic [1:0]  rx_c, drop_c;
  logic [2:0]  lvl_a, lvl_b, lvl_c;

  pkt_rx_unit #(.NODE_ID(4'd0), .ACCEPT_ANY(1'b0), .DEPTH(4), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave),
    .rx_count(rx_a), .drop_count(drop_a), .fifo_level(lvl_a));

  pkt_rx_unit #(.NODE_ID(4'd0), .ACCEPT_ANY(1'b1), .DEPTH(4), .CNT_W(16)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave),
    .rx_count(rx_b), .drop_count(drop_b), .fifo_level(lvl_b));

  pkt_rx_unit #(.NODE_ID(4'd0), .ACCEPT_ANY(1'b0), .DEPTH(4), .CNT_W(2)) dut_c (
    .clk(clk), .rst(rst), .bus(ifc.slave),
    .rx_count(rx_c), .drop_count(drop_c), .fifo_level(lvl_c));

  typedef struct {
    logic        rst;
    logic [32:0] pkt;
    logic        vld;
    logic        ordy;
    logic        e_rdy;
    logic        e_vld;
    logic [3:0]  e_op;
    logic [24:0] e_dat;
    logic [2:0]  e_lvl;
    logic [15:0] e_rx;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vt [20];

  function automatic logic [32:0] pk(input logic [3:0] a, input logic [3:0] op, input logic [24:0] d);
    return {a, op, d};
  endfunction

  function automatic vec_t mk(input logic r, input logic [32:0] p, input logic v, input logic o,
                              input logic erdy, input logic evld, input logic [3:0] eop,
                              input logic [24:0] edat, input logic [2:0] elvl,
                              input logic [15:0] erx, input logic [15:0] edrop);
    vec_t t;
    t.rst = r; t.pkt = p; t.vld = v; t.ordy = o;
    t.e_rdy = erdy; t.e_vld = evld; t.e_op = eop; t.e_dat = edat;
    t.e_lvl = elvl; t.e_rx = erx; t.e_drop = edrop;
    return t;
  endfunction

  function automatic logic [71:0] bundle(input logic rdy, input logic vld, input logic [3:0] op,
                                         input logic [24:0] dat, input logic [2:0] lvl,
                                         input logic [15:0] rx, input logic [15:0] drp);
    return {6'd0, rdy, vld, op, dat, lvl, rx, drp};
  endfunction

  task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Two reset edges; returns at a negedge with rst just released.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; pkt_valid = 1'b0; out_ready = 1'b0; pkt_in = '0;
    @(negedge clk);
    chk("rst_ready_low", 72'(ifa.pkt_ready), 72'(0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rel_ready_high", 72'(ifa.pkt_ready), 72'(1));
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = mk(1, '0,                        0, 0, 0, 0, 4'h0, 25'h0,       3'd0, 16'd0, 16'd0);
    vt[1]  = mk(1, '0,                        0, 0, 0, 0, 4'h0, 25'h0,       3'd0, 16'd0, 16'd0);
    vt[2]  = mk(0, '0,                        0, 0, 1, 0, 4'h0, 25'h0,       3'd0, 16'd0, 16'd0);
    vt[3]  = mk(0, pk(4'd0, 4'h3, 25'h1ABCDE), 1, 0, 1, 1, 4'h3, 25'h1ABCDE, 3'd1, 16'd1, 16'd0);
    vt[4]  = mk(0, pk(4'd5, 4'h7, 25'h0000AA), 1, 0, 1, 1, 4'h3, 25'h1ABCDE, 3'd1, 16'd1, 16'd1);
    vt[5]  = mk(0, '0,                        0, 1, 1, 0, 4'h0, 25'h0,       3'd0, 16'd1, 16'd1);
    vt[6]  = mk(0, pk(4'd0, 4'h1, 25'd1),      1, 0, 1, 1, 4'h1, 25'd1,       3'd1, 16'd2, 16'd1);
    vt[7]  = mk(0, pk(4'd0, 4'h2, 25'd2),      1, 0, 1, 1, 4'h1, 25'd1,       3'd2, 16'd3, 16'd1);
    vt[8]  = mk(0, pk(4'd0, 4'h4, 25'd3),      1, 0, 1, 1, 4'h1, 25'd1,       3'd3, 16'd4, 16'd1);
    vt[9]  = mk(0, pk(4'd0, 4'h5, 25'd4),      1, 0, 0, 1, 4'h1, 25'd1,       3'd4, 16'd5, 16'd1);
    vt[10] = mk(0, pk(4'd0, 4'h6, 25'd5),      1, 0, 0, 1, 4'h1, 25'd1,       3'd4, 16'd5, 16'd1);
    vt[11] = mk(0, pk(4'd0, 4'h6, 25'd5),      1, 1, 1, 1, 4'h2, 25'd2,       3'd3, 16'd5, 16'd1);
    vt[12] = mk(0, pk(4'd0, 4'h6, 25'd5),      1, 1, 1, 1, 4'h4, 25'd3,       3'd3, 16'd6, 16'd1);
    vt[13] = mk(0, pk(4'd0, 4'h7, 25'd6),      1, 1, 1, 1, 4'h5, 25'd4,       3'd3, 16'd7, 16'd1);
    vt[14] = mk(0, '0,                        0, 1, 1, 1, 4'h6, 25'd5,       3'd2, 16'd7, 16'd1);
    vt[15] = mk(0, '0,                        0, 1, 1, 1, 4'h7, 25'd6,       3'd1, 16'd7, 16'd1);
    vt[16] = mk(0, '0,                        0, 1, 1, 0, 4'h0, 25'h0,       3'd0, 16'd7, 16'd1);
    vt[17] = mk(0, pk(4'd0, 4'hF, 25'h1FFFFFF), 1, 0, 1, 1, 4'hF, 25'h1FFFFFF, 3'd1, 16'd8, 16'd1);
    vt[18] = mk(1, pk(4'd0, 4'h1, 25'd1),      1, 0, 0, 0, 4'h0, 25'h0,       3'd0, 16'd0, 16'd0);
    vt[19] = mk(0, '0,                        0, 0, 1, 0, 4'h0, 25'h0,       3'd0, 16'd0, 16'd0);

    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      rst = vt[i].rst; pkt_in = vt[i].pkt; pkt_valid = vt[i].vld; out_ready = vt[i].ordy;
      @(negedge clk);
      chk($sformatf("vec%0d", i),
          bundle(ifa.pkt_ready, ifa.out_valid, ifa.out_opcode, ifa.out_data, lvl_a, rx_a, drop_a),
          bundle(vt[i].e_rdy, vt[i].e_vld, vt[i].e_op, vt[i].e_dat, vt[i].e_lvl, vt[i].e_rx, vt[i].e_drop));
    end

    // Level held at 2 with simultaneous push/pop for 20 packets, then drain.
    do_reset();
    for (int k = 0; k < 2; k++) begin
      pkt_in = pk(4'd0, 4'(k), 25'(k)); pkt_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
    end
    for (int k = 2; k < 22; k++) begin
      pkt_in = pk(4'd0, 4'(k), 25'(k)); pkt_valid = 1'b1; out_ready = 1'b1;
      chk($sformatf("b2b_lvl%0d", k), 72'(lvl_a), 72'(2));
      chk($sformatf("b2b_head%0d", k), 72'({ifa.out_valid, ifa.out_opcode, ifa.out_data}),
          72'({1'b1, 4'(k - 2), 25'(k - 2)}));
      @(negedge clk);
    end
    pkt_valid = 1'b0;
    for (int k = 20; k < 22; k++) begin
      out_ready = 1'b1;
      chk($sformatf("drain_head%0d", k), 72'({ifa.out_valid, ifa.out_data}), 72'({1'b1, 25'(k)}));
      @(negedge clk);
    end
    chk("drain_end", bundle(ifa.pkt_ready, ifa.out_valid, ifa.out_opcode, ifa.out_data, lvl_a, rx_a, drop_a),
        bundle(1'b1, 1'b0, 4'h0, 25'h0, 3'd0, 16'd22, 16'd0));

    // Reset with three entries buffered and a packet offered in the reset cycle.
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k < 4; k++) begin
      pkt_in = pk(4'd0, 4'(k), 25'(k)); pkt_valid = 1'b1;
      @(negedge clk);
    end
    chk("pre_flush_lvl", 72'(lvl_a), 72'(3));
    rst = 1'b1; pkt_in = pk(4'd0, 4'h9, 25'd9); pkt_valid = 1'b1;
    @(negedge clk);
    chk("flush", bundle(ifa.pkt_ready, ifa.out_valid, ifa.out_opcode, ifa.out_data, lvl_a, rx_a, drop_a),
        bundle(1'b0, 1'b0, 4'h0, 25'h0, 3'd0, 16'd0, 16'd0));
    rst = 1'b0; pkt_valid = 1'b0;
    @(negedge clk);
    chk("post_flush", bundle(ifa.pkt_ready, ifa.out_valid, ifa.out_opcode, ifa.out_data, lvl_a, rx_a, drop_a),
        bundle(1'b1, 1'b0, 4'h0, 25'h0, 3'd0, 16'd0, 16'd0));

    // Foreign address: dropped by the default node, accepted by ACCEPT_ANY.
    do_reset();
    pkt_in = pk(4'd5, 4'h3, 25'h1ABCDE); pkt_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    pkt_valid = 1'b0;
    chk("mismatch_drop", bundle(ifa.pkt_ready, ifa.out_valid, ifa.out_opcode, ifa.out_data, lvl_a, rx_a, drop_a),
        bundle(1'b1, 1'b0, 4'h0, 25'h0, 3'd0, 16'd0, 16'd1));
    chk("accept_any", bundle(ifb.pkt_ready, ifb.out_valid, ifb.out_opcode, ifb.out_data, lvl_b, rx_b, drop_b),
        bundle(1'b1, 1'b1, 4'h3, 25'h1ABCDE, 3'd1, 16'd1, 16'd0));

    // Two-bit counters stick at 3.
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      pkt_in = pk(4'd0, 4'h1, 25'(k)); pkt_valid = 1'b1;
      @(negedge clk);
    end
    pkt_valid = 1'b0;
    chk("rx_sat", 72'(rx_c), 72'(3));
    for (int k = 0; k < 4; k++) begin
      pkt_in = pk(4'd7, 4'h1, 25'(k)); pkt_valid = 1'b1;
      @(negedge clk);
    end
    pkt_valid = 1'b0;
    chk("drop_sat", 72'({rx_c, drop_c}), 72'({2'd3, 2'd3}));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
